// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push handshake into the buffered UART transmitter.
interface uart_tx_buffered_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO; full/empty come from the occupancy count.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic [CNT_W-1:0] w_count_d;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_do_push = i_push && r_ready;
    assign w_do_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_count_d = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_d;
            r_ready <= (w_count_d != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_ready = r_ready;

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a small byte FIFO; bit timing advances on i_en ticks.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned OSR   = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    uart_tx_buffered_if.slave      io_bus,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned TICK_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic [1:0]           r_state;
    logic [TICK_W-1:0]    r_tick;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_ready;
    logic                 w_tick_last;
    logic [DATA_BITS-1:0] w_head;

    assign w_push      = io_bus.i_valid && w_ready;
    assign w_tick_last = (r_tick == TICK_W'(OSR - 1));
    // Pop when leaving IDLE or at the end of a stop bit, so queued frames run back to back.
    assign w_pop = i_en && (o_count != '0) &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick_last));

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (io_bus.i_data),
        .o_data  (w_head),
        .o_count (o_count),
        .o_ready (w_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= IDLE_LEVEL;
        end else if (i_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tick  <= '0;
                        r_tx    <= START_LEVEL;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick_last) begin
                        r_tick <= '0;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            r_tx      <= IDLE_LEVEL;
                            r_state   <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick_last) begin
                        r_tick <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= START_LEVEL;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.o_ready = w_ready;
    assign o_tx           = r_tx;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter OSR, default 16, i_en-qualified cycles per UART bit (minimum 2).
REQ-002 SHALL have parameter DEPTH, default 4, byte FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_en  input  1  oversample tick; the bit timer advances only on cycles where i_en=1.
REQ-006 SHALL have port i_data  input  8  byte to transmit.
REQ-007 SHALL have port i_valid  input  1  i_data is offered this cycle.
REQ-008 SHALL have port o_ready  output  1  the FIFO can accept a byte this cycle.
REQ-009 SHALL have port o_tx  output  1  serial line level; idle high; 8N1 framing, LSB first.
REQ-010 SHALL have port o_busy  output  1  a frame is in progress (state != IDLE).
REQ-011 SHALL have port o_count  output  $clog2(DEPTH)+1  number of bytes currently queued.

Function
REQ-012 SHALL push i_data on a cycle where i_valid=1 and o_ready=1, independent of i_en.
REQ-013 SHALL drive o_ready = (o_count != DEPTH), registered; i_valid while full is ignored, and the byte is not stored.
REQ-014 SHALL refuse a push when full even if a pop occurs the same cycle; the pop still occurs.
REQ-015 SHALL support a simultaneous push and pop when not full, leaving o_count unchanged.
REQ-016 SHALL use the states IDLE, START, DATA and STOP.
REQ-017 IDLE: on a cycle with i_en=1 and o_count>0, SHALL pop the head byte into the shift register, enter START and drive o_tx=0 from the next edge.
REQ-018 START/DATA/STOP: SHALL hold each bit for exactly OSR cycles with i_en=1, using a tick counter from 0 to OSR-1.
REQ-019 DATA: SHALL send 8 bits, LSB first, using a 3-bit bit index that wraps 7->0 on exit.
REQ-020 STOP: SHALL drive o_tx=1 for OSR ticks.
REQ-021 STOP end: if o_count>0, SHALL pop and enter START directly (back-to-back frames, no idle gap); otherwise SHALL enter IDLE.
REQ-022 SHALL freeze state, counters and o_tx while i_en=0; FIFO pushes continue.
REQ-023 SHALL make the first start bit appear at o_tx one cycle after the first i_en=1 IDLE cycle with o_count>0.
REQ-024 SHALL wrap FIFO read and write pointers modulo DEPTH.
REQ-025 SHALL derive the full and empty indications from o_count.

Reset
REQ-026 On i_rst=1, SHALL set o_tx=1, o_busy=0, o_count=0, o_ready=1, state=IDLE, all counters to 0 and both FIFO pointers to 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately, return o_tx high on the next edge and discard all queued bytes.
REQ-028 SHALL give i_rst priority over i_valid and i_en in the same cycle.

Structure
REQ-029 SHALL place the state enum, DATA_BITS=8, and the line levels IDLE_LEVEL=1 and START_LEVEL=0 in the shared uart package used by uart_rx and uart_tx.
REQ-030 SHALL implement the FIFO as one sub-module, uart_fifo (params WIDTH, DEPTH; ports push, pop, data in/out, count).
REQ-031 SHALL keep the serializer FSM in uart_tx_buffered itself; no other sub-modules.

Verification (OSR=4, DEPTH=4, i_en=1 unless stated)
REQ-032 Single byte: push 0xA5 -> o_tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; o_busy high for 40 cycles; o_count 1->0.
REQ-033 Back-to-back: push 0x00 then 0xFF -> two 40-cycle frames with no idle cycle between the first stop bit and the second start bit.
REQ-034 Overflow: hold i_valid with 0x11..0x16 while the first frame runs -> o_ready drops when o_count=4; refused bytes are never transmitted; the output sequence is exactly the accepted bytes in order.
REQ-035 Enable gating: i_en high 1 cycle in 3 -> each bit lasts 12 cycles; the waveform is otherwise identical to REQ-032.
REQ-036 Reset mid-frame: assert i_rst during DATA bit 3 of 0x3C with 2 bytes queued -> next edge o_tx=1, o_count=0, o_busy=0; after release, no further frames are sent.
REQ-037 Wrap-around: push and drain 10 bytes 0x00..0x09 in bursts of 3 -> all 10 bytes are received in order by a uart_rx model.
